tone_sequencer: RTL and testbench

Upstream feeder for the four-voice tone player.
- CPU/IO bus pushes timed chord commands: {duration, four 7-bit note IDs} into an internal FIFO.
- The sequencer pops each command, drives `noteID` with a one-cycle `we` write strobe, and holds it for `duration` ms ticks.
- When the FIFO runs dry, it writes silence (`noteID` = 0).
- Lets software queue melodies without cycle-accurate timing.

---
 rtl/tone_sequencer.sv | 174 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Chord sequencer: queues timed {duration, notes} commands and writes each chord to the
// four-voice tone player for its duration in ticks. Optional feature macro: TONESEQ_LOOP_EN.
module tone_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = 50000,
  parameter int DUR_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DUR_W+31:0]             cmd_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          flush,
`ifdef TONESEQ_LOOP_EN
  input  logic                          loop,
`endif
  output logic [31:0]                   noteID,
  output logic                          we,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // state   | meaning
  // IDLE    | nothing playing, waiting for a queued command
  // LOAD    | pop head, write its chord, load duration
  // PLAY    | hold chord, count ticks down to the end of the note
  // SILENCE | write the all-zero chord, then return to IDLE
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_SILENCE} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DUR_W + 32;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  state_t             state_q, state_d;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [EW-1:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [31:0]        note_q, note_d;
  logic               we_q, we_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [PW-1:0]      presc_q, presc_d;

  logic               loop_on;
  logic [EW-1:0]      head;
  logic               push_en;
  logic               pop_en;
  logic               recirc;
  logic               tick;
  logic               fifo_empty;

`ifdef TONESEQ_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q < DEPTH_C) && !flush && !loop_on;
  assign push_en    = cmd_valid && cmd_ready;
  assign pop_en     = (state_q == S_LOAD) && !flush;
  assign recirc     = pop_en && loop_on;
  assign tick       = (presc_q == PRESC_LAST);

  // A recirculated entry is written to the tail as the head leaves, so occupancy holds.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = cmd_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (recirc) begin
        mem_d[wr_ptr_q] = head;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en && !recirc);
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    we_d    = 1'b0;
    dur_d   = dur_q;
    presc_d = presc_q;
    if (flush) begin
      if (state_q == S_LOAD || state_q == S_PLAY) begin
        state_d = S_SILENCE;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) state_d = S_LOAD;
        end
        S_LOAD: begin
          note_d  = head[31:0];
          we_d    = 1'b1;
          dur_d   = head[EW-1:32];
          presc_d = '0;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            // Zero duration sustains until something new is queued.
            if (dur_q == '0) begin
              if (!fifo_empty) state_d = S_LOAD;
            end else if (dur_q == DUR_W'(1)) begin
              state_d = fifo_empty ? S_SILENCE : S_LOAD;
            end else begin
              dur_d = dur_q - DUR_W'(1);
            end
          end
        end
        S_SILENCE: begin
          note_d  = '0;
          we_d    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      note_q   <= '0;
      we_q     <= 1'b0;
      dur_q    <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      note_q   <= note_d;
      we_q     <= we_d;
      dur_q    <= dur_d;
      presc_q  <= presc_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign noteID     = note_q;
  assign we         = we_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: timeline-based reference model compared every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_tone_sequencer;

  localparam int TD = 4;
  localparam int FD = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW+31:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          flush;
  logic          loop;
  logic [31:0]   noteID;
  logic          we;
  logic          busy;
  logic [2:0]    fifo_count;

  tone_sequencer #(.FIFO_DEPTH(FD), .TICK_DIV(TD), .DUR_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .flush      (flush),
`ifdef TONESEQ_LOOP_EN
    .loop       (loop),
`endif
    .noteID     (noteID),
    .we         (we),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit we_seen;

  // Reference model: queue of commands plus a timeline measured from the last chord write.
  logic [DW+31:0] mq[$];
  int             m_since;    // cycles since the current chord was written
  int             m_left;     // remaining ticks (0 = sustain)
  int             m_next;     // write due at next edge: 0 none, 1 chord, 2 silence
  bit             m_hold;
  logic [31:0]    m_note;
  bit             m_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit pushed;
    int pre;
    logic [DW+31:0] h;
    pushed = cmd_valid && (mq.size() < FD) && !flush;
    m_we = 1'b0;
    if (reset) begin
      mq.delete();
      m_next = 0; m_hold = 0; m_note = '0;
      return;
    end
    if (flush) begin
      mq.delete();
      m_next = (m_next == 1 || m_hold) ? 2 : 0;
      m_hold = 0;
      return;
    end
    pre = mq.size();
    if (m_next == 1) begin
      h = mq.pop_front();
      m_note = h[31:0]; m_we = 1'b1; m_left = int'(h[DW+31:32]);
      m_hold = 1; m_since = 0; m_next = 0;
    end else if (m_next == 2) begin
      m_note = '0; m_we = 1'b1; m_next = 0;
    end else if (m_hold) begin
      m_since++;
      if (m_since % TD == 0) begin
        if (m_left > 1) m_left--;
        else if (m_left == 1) begin m_hold = 0; m_next = (pre != 0) ? 1 : 2; end
        else if (pre != 0) begin m_hold = 0; m_next = 1; end
      end
    end else if (pre != 0) begin
      m_next = 1;
    end
    if (pushed) mq.push_back(cmd_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    chk("noteID", 64'(noteID), 64'(m_note));
    chk("we", 64'(we), 64'(m_we));
    chk("busy", 64'(busy), 64'(m_next != 0 || m_hold));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("cmd_ready", 64'(cmd_ready), 64'((mq.size() < FD) && !flush));
    we_seen = (we === 1'b1);
  endtask

  task automatic push(input int dur, input logic [31:0] notes);
    cmd_data = {DW'(dur), notes};
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_we(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (we_seen) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL wait_we timeout cyc=%0d actual=no_pulse expected=pulse", cyc);
    end
  endtask

  initial begin
    int p, c1, c2, c3, fc, w0, e, n;
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_data = '0; loop = 1'b0;
    m_next = 0; m_hold = 0; m_note = '0; m_we = 0; m_since = 0; m_left = 0;

    // 1: reset
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_noteID", 64'(noteID), 64'h0);
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_count", 64'(fifo_count), 64'h0);
    chk("rst_ready", 64'(cmd_ready), 64'h1);
    repeat (2) cycle();

    // 2: single note, dur=3
    push(3, 32'h00302520); p = cyc;
    wait_we(20, c1);
    chk("t2_first_lat", 64'(c1 - p), 64'd2);
    chk("t2_note", 64'(noteID), 64'h00302520);
    wait_we(40, c2);
    chk("t2_sil_gap", 64'(c2 - c1), 64'd13);
    chk("t2_sil_note", 64'(noteID), 64'h0);
    cycle();
    chk("t2_busy_low", 64'(busy), 64'h0);
    repeat (3) cycle();

    // 3: back-to-back dur=2 then dur=1
    push(2, 32'h00000030);
    push(1, 32'h00000028);
    wait_we(20, c1);
    chk("t3_note1", 64'(noteID), 64'h30);
    wait_we(40, c2);
    chk("t3_gap1", 64'(c2 - c1), 64'd9);
    chk("t3_note2", 64'(noteID), 64'h28);
    wait_we(40, c3);
    chk("t3_gap2", 64'(c3 - c2), 64'd5);
    chk("t3_sil", 64'(noteID), 64'h0);
    repeat (3) cycle();

    // 4: fill FIFO while a long note plays
    push(100, 32'h00000011);
    wait_we(20, c1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_data = {DW'(50), 32'h00000101 + 32'(i)};
      cycle();
      if (i == 3) begin
        chk("t4_full_count", 64'(fifo_count), 64'd4);
        chk("t4_full_ready", 64'(cmd_ready), 64'd0);
      end
    end
    cmd_valid = 1'b0;
    chk("t4_fifth_dropped", 64'(fifo_count), 64'd4);
    wait_we(500, c2);
    chk("t4_gap", 64'(c2 - c1), 64'd401);
    chk("t4_next_note", 64'(noteID), 64'h101);
    chk("t4_count_after", 64'(fifo_count), 64'd3);
    chk("t4_ready_after", 64'(cmd_ready), 64'd1);

    // 5: flush mid-play with entries queued
    repeat (10) cycle();
    flush = 1'b1;
    cycle(); fc = cyc;
    flush = 1'b0;
    chk("t5_count_zero", 64'(fifo_count), 64'd0);
    wait_we(10, c1);
    chk("t5_sil_lat", 64'(c1 - fc), 64'd1);
    chk("t5_sil_note", 64'(noteID), 64'h0);
    cycle();
    chk("t5_busy_low", 64'(busy), 64'h0);
    repeat (3) cycle();

    // 6: sustain then a late push
    push(0, 32'h00000040);
    wait_we(20, w0);
    chk("t6_note", 64'(noteID), 64'h40);
    n = 0;
    repeat (50) begin
      cycle();
      if (we_seen) n++;
    end
    chk("t6_sustain_quiet", 64'(n), 64'd0);
    repeat (2) cycle();
    push(1, 32'h00000050); p = cyc;
    e = w0 + TD * ((p - w0) / TD + 1) + 1;
    wait_we(20, c1);
    chk("t6_late_lat", 64'(c1), 64'(e));
    chk("t6_late_note", 64'(noteID), 64'h50);
    wait_we(20, c2);
    chk("t6_sil_gap", 64'(c2 - c1), 64'd5);
    chk("t6_sil_note", 64'(noteID), 64'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      flush     = ($urandom_range(0, 79) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = {DW'($urandom_range(0, 3)), 32'($urandom)};
      cycle();
    end
    reset = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    repeat (30) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
